// File: rtl/taxi_pkg.sv
// Shared constants and helpers for the taxi meter front-end blocks.
package taxi_pkg;

  localparam int KM_W = 16;
  localparam logic [KM_W-1:0] KM_MAX = 16'd9999;
  localparam logic [3:0] POINT_KM = 4'b0010;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Synchronises an asynchronous level, filters bounce and emits a one-cycle
// registered tick on each accepted rising edge.
module sync_debounce
  import taxi_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50_000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic tick
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          s1_r;
  logic          s2_r;
  logic          deb_r;
  logic          deb_prev_r;
  logic          tick_r;
  logic [DW-1:0] dcnt_r;

  // Two-flop synchroniser, stability filter and rising-edge detector.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r       <= 1'b0;
      s2_r       <= 1'b0;
      deb_r      <= 1'b0;
      deb_prev_r <= 1'b0;
      tick_r     <= 1'b0;
      dcnt_r     <= {DW{1'b0}};
    end else begin
      s1_r       <= din;
      s2_r       <= s1_r;
      deb_prev_r <= deb_r;
      tick_r     <= deb_r & ~deb_prev_r;
      if (s2_r == deb_r) begin
        dcnt_r <= {DW{1'b0}};
      end else if (dcnt_r == DCNT_LAST) begin
        deb_r  <= s2_r;
        dcnt_r <= {DW{1'b0}};
      end else begin
        dcnt_r <= dcnt_r + DW'(1);
      end
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/wheel_odometer.sv
// Wheel-sensor odometer: debounced pulses become a saturating 0.1 km count,
// a per-100 m strobe, a sticky overflow flag and a moving/stalled indication.
module wheel_odometer
  import taxi_pkg::*;
#(
  parameter int PULSES_PER_100M = 10,
  parameter int DEBOUNCE_CYCLES = 50_000,
  parameter int STALL_CYCLES    = 100_000_000
) (
  input  logic            sys_clk,
  input  logic            sys_reset,
  input  logic            wheel_in,
  input  logic            en,
  input  logic            km_clr,
  output logic [KM_W-1:0] data_km,
  output logic [3:0]      point,
  output logic            pulse_100m,
  output logic            moving,
  output logic            overflow
);

  localparam int PW = cnt_width(PULSES_PER_100M);
  localparam int SW = cnt_width(STALL_CYCLES + 1);
  localparam logic [PW-1:0] PCNT_LAST = PW'(PULSES_PER_100M - 1);
  localparam logic [SW-1:0] SCNT_MAX  = SW'(STALL_CYCLES);
  localparam logic [SW-1:0] SCNT_MOVE = SW'(STALL_CYCLES - 1);

  logic            tick_s;
  logic            step_s;
  logic [PW-1:0]   pcnt_r;
  logic [KM_W-1:0] data_km_r;
  logic            pulse_r;
  logic            ovf_r;
  logic [SW-1:0]   scnt_r;
  logic            moving_r;
  logic [3:0]      point_r;

  sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sync (
    .clk  (sys_clk),
    .rst  (sys_reset),
    .din  (wheel_in),
    .tick (tick_s)
  );

  assign step_s = tick_s & en & (pcnt_r == PCNT_LAST);

  // Distance accumulation; a clear outranks a tick arriving in the same cycle.
  always_ff @(posedge sys_clk) begin
    if (sys_reset || km_clr) begin
      pcnt_r    <= {PW{1'b0}};
      data_km_r <= {KM_W{1'b0}};
      pulse_r   <= 1'b0;
      ovf_r     <= 1'b0;
    end else begin
      pulse_r <= 1'b0;
      if (tick_s && en) begin
        pcnt_r <= step_s ? {PW{1'b0}} : pcnt_r + PW'(1);
      end
      if (step_s) begin
        if (data_km_r < KM_MAX) begin
          data_km_r <= data_km_r + 16'd1;
          pulse_r   <= 1'b1;
        end else begin
          ovf_r <= 1'b1;
        end
      end
    end
  end

  // Stall timer: restarted by every accepted wheel edge, paused or not.
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      scnt_r   <= SCNT_MAX;
      moving_r <= 1'b0;
    end else begin
      if (tick_s) begin
        scnt_r <= {SW{1'b0}};
      end else if (scnt_r < SCNT_MAX) begin
        scnt_r <= scnt_r + SW'(1);
      end
      moving_r <= (scnt_r < SCNT_MOVE);
    end
  end

  // Display decimal-point mask, held in a register like every other output.
  always_ff @(posedge sys_clk) begin
    point_r <= POINT_KM;
  end

  assign data_km    = data_km_r;
  assign point      = point_r;
  assign pulse_100m = pulse_r;
  assign moving     = moving_r;
  assign overflow   = ovf_r;

endmodule

// File: tb/tb_wheel_odometer.sv
// Scoreboard bench for wheel_odometer with a small distance model.
module tb_wheel_odometer;

  localparam int P          = 3;
  localparam int D          = 4;
  localparam int S          = 50;
  localparam int TICK_OFS   = D + 3;
  localparam int STROBE_LAT = D + 4;

  logic        sys_clk   = 1'b0;
  logic        sys_reset = 1'b1;
  logic        wheel_in  = 1'b0;
  logic        en        = 1'b0;
  logic        km_clr    = 1'b0;
  logic [15:0] data_km;
  logic [3:0]  point;
  logic        pulse_100m;
  logic        moving;
  logic        overflow;

  typedef struct {
    logic [15:0] km;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int   n_vec      = 0;
  int   n_err      = 0;
  int   cycle_cnt  = 0;
  int   strobe_cnt = 0;
  int   tick_cnt   = 0;
  int   model_pcnt = 0;
  int   model_km   = 0;
  bit   model_ovf  = 1'b0;

  wheel_odometer #(
    .PULSES_PER_100M(P),
    .DEBOUNCE_CYCLES(D),
    .STALL_CYCLES   (S)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_reset  (sys_reset),
    .wheel_in   (wheel_in),
    .en         (en),
    .km_clr     (km_clr),
    .data_km    (data_km),
    .point      (point),
    .pulse_100m (pulse_100m),
    .moving     (moving),
    .overflow   (overflow)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cycle_cnt <= cycle_cnt + 1;

  // Strobe monitor: every pulse_100m must match the next scoreboard entry.
  always @(negedge sys_clk) begin
    if (dut.u_sync.tick_r === 1'b1) tick_cnt++;
    if (sys_reset === 1'b0 && pulse_100m === 1'b1) begin
      strobe_cnt++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL strobe_unexpected: got strobe at cycle %0d data_km=%0d, required none", cycle_cnt, data_km);
      end else begin
        e_mon = exp_q.pop_front();
        if (data_km !== e_mon.km || cycle_cnt != e_mon.cyc) begin
          n_err++;
          $display("FAIL strobe: got data_km=%0d at cycle %0d, required %0d at cycle %0d",
                   data_km, cycle_cnt, e_mon.km, e_mon.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    model_pcnt = 0;
    model_km   = 0;
    model_ovf  = 1'b0;
  endtask

  // One clean wheel pulse (high 8, low 8); optionally km_clr on the tick cycle.
  task automatic wheel_pulse(input bit clr_on_tick);
    int n;
    @(posedge sys_clk); #1;
    wheel_in = 1'b1;
    n = cycle_cnt;
    if (clr_on_tick) begin
      model_clear();
    end else if (en) begin
      if (model_pcnt == P - 1) begin
        model_pcnt = 0;
        if (model_km < 9999) begin
          model_km++;
          exp_q.push_back('{km: 16'(model_km), cyc: n + STROBE_LAT});
        end else begin
          model_ovf = 1'b1;
        end
      end else begin
        model_pcnt++;
      end
    end
    for (int i = 1; i < 16; i++) begin
      @(posedge sys_clk); #1;
      if (i == 8) wheel_in = 1'b0;
      km_clr = clr_on_tick && (i == TICK_OFS);
    end
    km_clr = 1'b0;
  endtask

  task automatic do_clear();
    @(posedge sys_clk); #1;
    km_clr = 1'b1;
    @(posedge sys_clk); #1;
    km_clr = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    sys_reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge sys_clk); #1;
      wheel_in = ~wheel_in;
    end
    @(negedge sys_clk);
    n_vec += 5;
    if (data_km !== 16'd0) begin n_err++; $display("FAIL reset_data_km: got %0d, required 0", data_km); end
    if (point !== 4'b0010) begin n_err++; $display("FAIL reset_point: got %b, required 0010", point); end
    if (moving !== 1'b0) begin n_err++; $display("FAIL reset_moving: got %b, required 0", moving); end
    if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
    if (pulse_100m !== 1'b0) begin n_err++; $display("FAIL reset_pulse: got %b, required 0", pulse_100m); end
    @(posedge sys_clk); #1;
    sys_reset = 1'b0;
    wheel_in  = 1'b0;
    model_clear();
    repeat (12) @(negedge sys_clk);
    n_vec += 3;
    if (data_km !== 16'd0) begin n_err++; $display("FAIL post_reset_data_km: got %0d, required 0", data_km); end
    if (moving !== 1'b0) begin n_err++; $display("FAIL post_reset_moving: got %b, required 0", moving); end
    if (point !== 4'b0010) begin n_err++; $display("FAIL post_reset_point: got %b, required 0010", point); end
  endtask

  task automatic test_bounce();
    int t0;
    int s0;
    en = 1'b1;
    t0 = tick_cnt;
    for (int g = 0; g < 10; g++) begin
      @(posedge sys_clk); #1;
      wheel_in = 1'b1;
      repeat (3) @(posedge sys_clk);
      #1;
      wheel_in = 1'b0;
      repeat (7) @(posedge sys_clk);
    end
    @(negedge sys_clk);
    n_vec += 2;
    if (tick_cnt != t0) begin n_err++; $display("FAIL glitch_tick: got %0d ticks, required 0", tick_cnt - t0); end
    if (data_km !== 16'd0) begin n_err++; $display("FAIL glitch_data_km: got %0d, required 0", data_km); end
    s0 = strobe_cnt;
    for (int k = 0; k < 6; k++) wheel_pulse(1'b0);
    repeat (4) @(negedge sys_clk);
    n_vec += 2;
    if (data_km !== 16'd2) begin n_err++; $display("FAIL clean_data_km: got %0d, required 2", data_km); end
    if (strobe_cnt - s0 != 2) begin n_err++; $display("FAIL clean_strobes: got %0d, required 2", strobe_cnt - s0); end
  endtask

  task automatic test_pause();
    int s0;
    do_clear();
    s0 = strobe_cnt;
    en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      en = (k < 2 || k == 7) ? 1'b1 : 1'b0;
      wheel_pulse(1'b0);
      @(negedge sys_clk);
      n_vec++;
      if (moving !== 1'b1) begin n_err++; $display("FAIL pause_moving[%0d]: got %b, required 1", k, moving); end
    end
    en = 1'b1;
    n_vec += 2;
    if (data_km !== 16'd1) begin n_err++; $display("FAIL pause_data_km: got %0d, required 1", data_km); end
    if (strobe_cnt - s0 != 1) begin n_err++; $display("FAIL pause_strobes: got %0d, required 1", strobe_cnt - s0); end
  endtask

  task automatic test_saturation();
    int s0;
    do_clear();
    @(negedge sys_clk);
    force dut.data_km_r = 16'd9998;
    @(negedge sys_clk);
    release dut.data_km_r;
    model_km = 9998;
    for (int k = 0; k < 3; k++) wheel_pulse(1'b0);
    @(negedge sys_clk);
    n_vec += 2;
    if (data_km !== 16'd9999) begin n_err++; $display("FAIL sat_reach: got %0d, required 9999", data_km); end
    if (overflow !== 1'b0) begin n_err++; $display("FAIL sat_reach_ovf: got %b, required 0", overflow); end
    s0 = strobe_cnt;
    for (int k = 0; k < 3; k++) wheel_pulse(1'b0);
    @(negedge sys_clk);
    n_vec += 3;
    if (data_km !== 16'd9999) begin n_err++; $display("FAIL sat_hold: got %0d, required 9999", data_km); end
    if (overflow !== model_ovf) begin n_err++; $display("FAIL sat_ovf: got %b, required %b", overflow, model_ovf); end
    if (strobe_cnt != s0) begin n_err++; $display("FAIL sat_strobe: got %0d strobes, required 0", strobe_cnt - s0); end
    do_clear();
    @(negedge sys_clk);
    n_vec += 2;
    if (data_km !== 16'd0) begin n_err++; $display("FAIL clr_data_km: got %0d, required 0", data_km); end
    if (overflow !== 1'b0) begin n_err++; $display("FAIL clr_ovf: got %b, required 0", overflow); end
  endtask

  task automatic test_stall();
    int n;
    int w;
    w = 0;
    while (moving !== 1'b0 && w < 200) begin
      @(negedge sys_clk);
      w++;
    end
    n_vec++;
    if (moving !== 1'b0) begin n_err++; $display("FAIL stall_idle: got moving=%b, required 0", moving); end
    en = 1'b1;
    n = cycle_cnt + 1;
    fork
      wheel_pulse(1'b0);
      begin
        while (cycle_cnt < n + 60) begin
          @(negedge sys_clk);
          if (cycle_cnt == n + 8 || cycle_cnt == n + 9 || cycle_cnt == n + 57 || cycle_cnt == n + 58) begin
            n_vec++;
            if (moving !== ((cycle_cnt == n + 9 || cycle_cnt == n + 57) ? 1'b1 : 1'b0)) begin
              n_err++;
              $display("FAIL stall_moving: got %b at pulse+%0d", moving, cycle_cnt - n);
            end
          end
        end
      end
    join
  endtask

  task automatic test_simul_clear();
    int s0;
    do_clear();
    en = 1'b1;
    wheel_pulse(1'b0);
    wheel_pulse(1'b0);
    s0 = strobe_cnt;
    wheel_pulse(1'b1);
    @(negedge sys_clk);
    n_vec += 2;
    if (data_km !== 16'd0) begin n_err++; $display("FAIL simclr_data_km: got %0d, required 0", data_km); end
    if (strobe_cnt != s0) begin n_err++; $display("FAIL simclr_strobe: got %0d, required 0", strobe_cnt - s0); end
    for (int k = 0; k < 3; k++) wheel_pulse(1'b0);
    @(negedge sys_clk);
    n_vec++;
    if (data_km !== 16'd1) begin n_err++; $display("FAIL simclr_pcnt: got data_km=%0d, required 1", data_km); end
  endtask

  task automatic test_mid_reset();
    int n;
    en = 1'b0;
    @(posedge sys_clk); #1;
    wheel_in = 1'b1;
    n = cycle_cnt;
    repeat (3) @(posedge sys_clk);
    #1;
    sys_reset = 1'b1;
    @(posedge sys_clk); #1;
    sys_reset = 1'b0;
    model_clear();
    while (cycle_cnt < n + 11) begin
      @(negedge sys_clk);
      n_vec++;
      if (dut.u_sync.deb_r !== ((cycle_cnt >= n + 10) ? 1'b1 : 1'b0)) begin
        n_err++;
        $display("FAIL midrst_deb: got %b at wheel+%0d", dut.u_sync.deb_r, cycle_cnt - n);
      end
    end
    n_vec += 2;
    if (data_km !== 16'd0) begin n_err++; $display("FAIL midrst_data_km: got %0d, required 0", data_km); end
    if (overflow !== 1'b0) begin n_err++; $display("FAIL midrst_ovf: got %b, required 0", overflow); end
    @(posedge sys_clk); #1;
    wheel_in = 1'b0;
    repeat (20) @(posedge sys_clk);
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_pause();
    test_saturation();
    test_stall();
    test_simul_clear();
    test_mid_reset();
    repeat (10) @(negedge sys_clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL strobe_missing: got %0d outstanding, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
